// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M/RV64M multiply/divide unit.
// Op encodings follow funct3 of the M extension.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } md_state_e;

    // {in1 signed, in2 signed}
    function automatic logic [1:0] is_signed_op(md_op_e op);
        case (op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: is_signed_op = 2'b11;
            MD_MULHSU:                       is_signed_op = 2'b10;
            default:                         is_signed_op = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Radix-2 multiply / restoring divide unit with a 1-cycle path
// for divide-by-zero and signed overflow.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state;
    md_op_e            op_q;
    logic              div_q;
    logic              neg_q;
    logic [XLEN-1:0]   mag_q;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result_q;

    md_op_e          op_in;
    logic [1:0]      sgn;
    logic            n1, n2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, ovf, special, sign_in;
    logic [XLEN-1:0] special_res;

    assign op_in    = md_op_e'(op);
    assign sgn      = is_signed_op(op_in);
    assign n1       = sgn[1] & in1[XLEN-1];
    assign n2       = sgn[0] & in2[XLEN-1];
    assign mag1     = n1 ? -in1 : in1;
    assign mag2     = n2 ? -in2 : in2;
    assign div_zero = op[2] && (in2 == '0);
    assign ovf      = op[2] && !op[0] && (in1 == MOST_NEG) && (&in2);
    assign special  = div_zero | ovf;
    // Remainder takes the dividend's sign; everything else the xor.
    assign sign_in  = (op[2] && op[1]) ? n1 : (n1 ^ n2);

    always_comb begin
        special_res = '0;
        unique case (1'b1)
            div_zero && !op[1]: special_res = '1;
            div_zero &&  op[1]: special_res = in1;
            ovf && !op[1]:      special_res = in1;
            default:            special_res = '0;
        endcase
    end

    logic [XLEN:0]     sum, trial;
    logic [2*XLEN-1:0] step_acc;

    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mag_q};
        trial = acc[2*XLEN-1:XLEN-1] - {1'b0, mag_q};
        if (div_q) begin
            if (trial[XLEN])
                step_acc = {acc[2*XLEN-2:0], 1'b0};
            else
                step_acc = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else if (acc[0]) begin
            step_acc = {sum, acc[XLEN-1:1]};
        end else begin
            step_acc = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin;

    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = neg_q ? -step_acc[2*XLEN-1:XLEN]
                     : step_acc[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                        fin = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fin = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fin = quo;
            default:                       fin = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= MD_MUL;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q  <= op_in;
                    div_q <= op[2];
                    neg_q <= sign_in;
                    mag_q <= mag2;
                    acc   <= {{XLEN{1'b0}}, mag1};
                    cnt   <= CW'(XLEN - 1);
                    if (special) begin
                        result_q <= special_res;
                        state    <= S_DONE;
                    end else begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc <= step_acc;
                    if (cnt == '0) begin
                        result_q <= fin;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=64.
// Expected results come from wide-integer arithmetic on the operands.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  op_r = 3'd0;
    logic [63:0] a_r = '0;
    logic [63:0] b_r = '0;
    logic        flush = 1'b0;
    logic        sel = 1'b0;
    logic        rand_rdy = 1'b0;
    logic        force_rdy = 1'b1;
    logic        rnd_bit = 1'b1;
    logic        ordy;

    logic        r32, ov32, bz32, r64, ov64, bz64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic        rdy, ov, bz;
    logic [63:0] res, mask, mneg;

    always #5 clk = ~clk;

    assign ordy = rand_rdy ? rnd_bit : force_rdy;
    assign rdy  = sel ? r64 : r32;
    assign ov   = sel ? ov64 : ov32;
    assign bz   = sel ? bz64 : bz32;
    assign res  = sel ? res64 : {32'd0, res32};
    assign mask = sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    assign mneg = sel ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;

    muldiv_unit #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & ~sel), .in_ready(r32),
        .op(op_r), .in1(a_r[31:0]), .in2(b_r[31:0]),
        .flush(flush), .out_valid(ov32), .out_ready(ordy),
        .result(res32), .busy(bz32)
    );

    muldiv_unit #(.XLEN(64)) u64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid & sel), .in_ready(r64),
        .op(op_r), .in1(a_r), .in2(b_r),
        .flush(flush), .out_valid(ov64), .out_ready(ordy),
        .result(res64), .busy(bz64)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          start;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        seen = 1'b0;
    logic [63:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    function automatic logic signed [129:0] ext(input logic [63:0] v,
                                                input int xl, input logic s);
        logic signed [129:0] t;
        if (xl == 32) begin
            if (s) t = $signed(v[31:0]);
            else   t = {98'd0, v[31:0]};
        end else begin
            if (s) t = $signed(v);
            else   t = {66'd0, v};
        end
        return t;
    endfunction

    function automatic logic [63:0] ref_res(input int xl, input logic [2:0] o,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [129:0] x, y, r;
        logic [63:0] m;
        logic s1, s2;
        m  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        s1 = (o == 3'd0) || (o == 3'd1) || (o == 3'd2) ||
             (o == 3'd4) || (o == 3'd6);
        s2 = (o == 3'd0) || (o == 3'd1) || (o == 3'd4) || (o == 3'd6);
        x  = ext(a, xl, s1);
        y  = ext(b, xl, s2);
        if (o[2] && y == 0) r = o[1] ? x : -130'sd1;
        else begin
            case (o)
                3'd0:             r = x * y;
                3'd1, 3'd2, 3'd3: r = (x * y) >>> xl;
                3'd4, 3'd5:       r = x / y;
                default:          r = x % y;
            endcase
        end
        return 64'(r) & m;
    endfunction

    function automatic int exp_lat();
        logic sp;
        sp = op_r[2] && (b_r == 0 ||
             (!op_r[0] && a_r == mneg && b_r == mask));
        return sp ? 1 : (sel ? 65 : 33);
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = mask;
            2:       v = mneg;
            3:       v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    task automatic drive(input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y);
        op_r     = o;
        a_r      = x & mask;
        b_r      = y & mask;
        in_valid = 1'b1;
    endtask

    task automatic accept(input logic [63:0] e);
        int n;
        exp_t t;
        n = 0;
        while (!rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) chk("accept_timeout", 64'(rdy), 64'd1);
        else begin
            t.res   = e & mask;
            t.lat   = exp_lat();
            t.start = cyc;
            q.push_back(t);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_r = {$urandom, $urandom};
        b_r = {$urandom, $urandom};
    endtask

    task automatic go(input logic [2:0] o, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] e);
        @(negedge clk);
        drive(o, x, y);
        accept(e);
    endtask

    task automatic go_rand(input int cnt);
        logic [2:0]  o;
        logic [63:0] x, y;
        for (int i = 0; i < cnt; i++) begin
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            go(o, x, y, ref_res(sel ? 64 : 32, o, x, y));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
    endtask

    task automatic set_mode(input logic s, input logic r, input logic f);
        @(posedge clk);
        #1;
        sel       = s;
        rand_rdy  = r;
        force_rdy = f;
    endtask

    always @(negedge clk) begin
        if (rst_n && ov) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 64'(ov), 64'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    held = res;
                    chk("latency", 64'(cyc - q[0].start), 64'(q[0].lat));
                end else begin
                    chk("result_stable", res, held);
                end
                if (ordy) begin
                    chk("result", res, q[0].res);
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, hs, n;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("reset_in_ready", 64'(rdy), 64'd1);
            chk("reset_out_valid", 64'(ov), 64'd0);
            chk("reset_busy", 64'(bz), 64'd0);
            chk("reset_result", res, 64'd0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        go(3'd0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk("t1_busy", 64'(bz), 64'(k <= 33));
        end
        chk("t1_in_ready_after", 64'(rdy), 64'd1);

        go(3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000);
        go(3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
        go(3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        go(3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD);
        go(3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF);
        go(3'd5, 64'd100, 64'd7, 64'd14);
        go(3'd7, 64'd100, 64'd7, 64'd2);
        drain();

        go(3'd0, 64'd3, 64'd5, 64'd15);
        st = q[$].start;
        while (cyc < st + 5) @(negedge clk);
        chk("rst_pre_busy", 64'(bz), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 64'(rdy), 64'd1);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_busy", 64'(bz), 64'd0);
        chk("rst_result", res, 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        go(3'd5, 64'd5, 64'd0, 64'hFFFF_FFFF);
        go(3'd6, 64'd5, 64'd0, 64'd5);
        go(3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
        go(3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
        drain();

        set_mode(1'b0, 1'b0, 1'b0);
        go(3'd5, 64'd100, 64'd7, 64'd14);
        n = 0;
        while (!ov && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_valid", 64'(ov), 64'd1);
        drive(3'd0, 64'd9, 64'd9);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready_low", 64'(rdy), 64'd0);
            chk("bp_valid_held", 64'(ov), 64'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        force_rdy = 1'b1;
        hs = cyc;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_dropped", 64'(ov), 64'd0);
        chk("bp_ready_back", 64'(rdy), 64'd1);
        accept(64'd81);
        chk("bp_accept_cycle", 64'(q[$].start), 64'(hs + 1));
        drain();

        go(3'd4, 64'd1000, 64'd7, 64'd142);
        st = q[$].start;
        while (cyc < st + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 64'(bz), 64'd0);
        chk("flush_out_valid", 64'(ov), 64'd0);
        chk("flush_in_ready", 64'(rdy), 64'd1);
        q.delete();
        repeat (40) @(negedge clk);
        go(3'd4, 64'd1000, 64'd7, 64'd142);
        drain();

        set_mode(1'b0, 1'b1, 1'b1);
        go_rand(40);
        drain();

        set_mode(1'b1, 1'b0, 1'b1);
        go(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        go(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        go(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        go(3'd5, 64'd100, 64'd7, 64'd14);
        go(3'd7, 64'd100, 64'd7, 64'd2);
        drain();
        set_mode(1'b1, 1'b1, 1'b1);
        go_rand(30);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit implementing the RV32M/RV64M operations as a multi-cycle companion to the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake. It computes with a radix-2 shift-add or restoring-division datapath over XLEN cycles, or a 1-cycle fast path for divide special cases, then holds the result until the pipeline consumes it. The hazard unit stalls on `busy`, and a pipeline flush cancels the operation in flight.

## Interface
- `XLEN`, default 32: operand/result width; legal values 32, 64.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept a request (IDLE only).
- `op`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `in1`, `in2`  in  XLEN  operands (rs1, rs2).
- `flush`  in  1  cancel any operation and return to IDLE.
- `out_valid`  out  1  `result` is valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  XLEN  operation result.
- `busy`  out  1  high in CALC or DONE.

## Operation
- States:
  - IDLE → CALC on accept (`in_valid && in_ready`, normal case).
  - IDLE → DONE on accept of a special case.
  - CALC → DONE when the step counter reaches 0.
  - DONE → IDLE on `out_valid && out_ready`.
- `flush` from any state → IDLE at the next edge. No result is produced. `flush` takes priority over a simultaneous accept or output handshake.
- On accept, register `op` and the operand magnitudes. The magnitude is `|x|` if the operand is signed for this op and negative, otherwise `x`. Register the result-sign flag. Load the counter with XLEN-1.
- Signedness of operands:
  - MUL/MULH: both operands signed.
  - MULHSU: `in1` signed, `in2` unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - DIV/REM: both signed. The quotient sign is `s1^s2`; the remainder sign is `s1`.
- Multiply: one shift-add step per CALC cycle into a 2·XLEN accumulator. The final product is negated if the sign flag is set. MUL returns the low XLEN bits; the MULH* ops return the high XLEN bits.
- Divide: one restoring step per CALC cycle (shift remainder, trial subtract, set quotient bit). The quotient/remainder sign is corrected in the last step.
- Special cases, fast path (no CALC):
  - Divisor 0: DIV/DIVU → all-ones; REM/REMU → `in1`.
  - Signed overflow (`in1` = most-negative, `in2` = -1): DIV → most-negative; REM → 0.
- `result` is registered. It is loaded only on entry to DONE and held stable while `out_valid && !out_ready`.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `result`=0, counter=0.
- Asserting `rst_n` low mid-operation forces all outputs to their reset values asynchronously.

## Timing
- Handshake in cycle 0, normal case: CALC occupies cycles 1..XLEN; `out_valid` rises in cycle XLEN+1. For XLEN=32 that is cycle 33.
- Handshake in cycle 0, special case: `out_valid` in cycle 1.
- Output handshake in cycle N: `out_valid`=0 and `in_ready`=1 in cycle N+1. There is no back-to-back accept in the same cycle as the output handshake.
- `in_ready` is combinational from state only, not from `in_valid`.
- `flush` in cycle N: `busy`=0, `out_valid`=0, `in_ready`=1 in cycle N+1.
- Operands need only be valid in the handshake cycle.

## Structure
- Shared package `muldiv_pkg`:
  - `md_op_e` enum (the funct3 encodings above).
  - `md_state_e` enum (IDLE, CALC, DONE).
  - Function `is_signed_op`.
- Single module; no sub-module. Multiply and divide share the accumulator and counter.
- Counter width is $clog2(XLEN).

## Test plan
Each case uses XLEN=32 unless stated.
1. MUL 7 × 0xFFFFFFFD → `result` 0xFFFFFFEB, `out_valid` first seen cycle 33, `busy` high cycles 1–33.
2. High products:
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
3. Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
4. Special cases, `out_valid` in cycle 1:
   - DIVU 5 / 0 → 0xFFFFFFFF.
   - REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM of the same operands → 0.
5. Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `result` stable, `in_ready`=0 throughout, and a pending `in_valid` is not accepted until the cycle after the output handshake.
6. `flush` in cycle 10 of a DIV → IDLE in cycle 11, no `out_valid`, and the next op completes correctly. `rst_n` low in cycle 5 → outputs at their reset values immediately. Repeat tests 1 and 3 with XLEN=64.
